// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory arbiter.
// Holds default widths, the starvation limit and the grant-select enum.
package mem_arb_pkg;

    localparam int AW         = 32;
    localparam int DW         = 32;
    localparam int MAX_STARVE = 4;
    localparam int STARVE_W   = 4;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_IF,
        GNT_D
    } gnt_sel_e;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of cycles the fetch port has waited for a grant.
// force_if rises once the wait reaches MAX_STARVE.
module mem_arb_starve_cnt
    import mem_arb_pkg::*;
#(
    parameter int MAX_STARVE = mem_arb_pkg::MAX_STARVE
) (
    input  logic clk,
    input  logic reset_n,
    input  logic if_req,
    input  logic if_gnt,
    output logic force_if
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(MAX_STARVE);

    logic [STARVE_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (!if_req || if_gnt) begin
            cnt <= '0;
        end else if (cnt != LIMIT) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign force_if = (cnt == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for the single-port unified memory, data-priority.
// Define MEM_ARB_ADDR_CHECK_EN to flag out-of-range or misaligned accesses.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = mem_arb_pkg::AW,
    parameter int DW         = mem_arb_pkg::DW,
    parameter int MAX_STARVE = mem_arb_pkg::MAX_STARVE,
    parameter int MEM_WORDS  = 128
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd,
    output logic          err
);

    if (MAX_STARVE < 1 || MAX_STARVE > 15 || MEM_WORDS < 1) begin : g_cfg_err
        $error("mem_arbiter: illegal parameter configuration");
    end

    gnt_sel_e sel;
    logic     force_if;
    logic     addr_err;

    always_comb begin
        sel = GNT_NONE;
        if (reset_n) begin
            if (d_req && !(if_req && force_if)) begin
                sel = GNT_D;
            end else if (if_req) begin
                sel = GNT_IF;
            end
        end
    end

    assign if_gnt = (sel == GNT_IF);
    assign d_gnt  = (sel == GNT_D);
    assign mem_a  = d_gnt ? d_addr : if_addr;
    assign mem_wd = d_wdata;

`ifdef MEM_ARB_ADDR_CHECK_EN
    // Word index compared at full width so large addresses cannot alias.
    assign addr_err = (if_gnt || d_gnt) &&
                      (({2'b00, mem_a[AW-1:2]} >= AW'(MEM_WORDS)) ||
                       (mem_a[1:0] != 2'b00));
`else
    assign addr_err = 1'b0;
`endif

    assign mem_we = d_gnt && d_we && !addr_err;

    mem_arb_starve_cnt #(
        .MAX_STARVE(MAX_STARVE)
    ) u_starve (
        .clk      (clk),
        .reset_n  (reset_n),
        .if_req   (if_req),
        .if_gnt   (if_gnt),
        .force_if (force_if)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_rvalid <= if_gnt;
            d_rvalid  <= d_gnt;
            if (if_gnt) begin
                if_rdata <= addr_err ? '0 : mem_rd;
            end
            if (d_gnt) begin
                d_rdata <= (d_we || addr_err) ? '0 : mem_rd;
            end
        end
    end

`ifdef MEM_ARB_ADDR_CHECK_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err <= 1'b0;
        end else begin
            err <= addr_err;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single-port unified instruction/data memory between two requesters: the instruction-fetch unit (IF port) and the load/store unit (D port).
- Grants one access per cycle to the memory.
- Drives the memory's write enable, word address and write data.
- Captures the memory's asynchronous read data and returns it one cycle later, tagged to the winning requester.
- Data has priority, with a bounded-starvation guarantee for fetch.
- Sits between the core front/back ends and the memory.

Parameters:
- AW, 32, address width of requester and memory ports.
- DW, 32, data width.
- MAX_STARVE, 4, maximum consecutive cycles IF may request without a grant before IF is forced to win (1..15).
- MEM_WORDS, 128, memory depth in words; used only by the optional address check.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- if_req  in  1  fetch request; held with if_addr stable until if_gnt
- if_addr  in  AW  fetch byte address
- if_gnt  out  1  fetch accepted this cycle (combinational)
- if_rvalid  out  1  fetch data valid (registered)
- if_rdata  out  DW  fetch data
- d_req  in  1  data request; held stable until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data byte address
- d_wdata  in  DW  store data
- d_gnt  out  1  data accepted this cycle (combinational)
- d_rvalid  out  1  load data valid, or store completion (registered)
- d_rdata  out  DW  load data; 0 for stores
- mem_we  out  1  memory write enable
- mem_a  out  AW  memory byte address
- mem_wd  out  DW  memory write data
- mem_rd  in  DW  memory read data (asynchronous)
- err  out  1  address-range error pulse (see Optional Feature)

Behaviour:
- Reset (reset_n = 0 at a clk edge) clears the following; all outputs become 0 next cycle:
  - starve_cnt = 0
  - if_rvalid = 0, d_rvalid = 0
  - if_rdata = 0, d_rdata = 0
  - err = 0
- During reset, if_gnt, d_gnt and mem_we are forced to 0.
- Grant is combinational each cycle:
  - d_req only: d_gnt = 1.
  - if_req only: if_gnt = 1.
  - Both requesting: d_gnt = 1, unless starve_cnt == MAX_STARVE, in which case if_gnt = 1.
  - At most one grant per cycle; no request means no grant and mem_we = 0.
- Memory mux:
  - mem_a = address of the granted port; when idle, mem_a = if_addr.
  - mem_we = d_gnt & d_we.
  - mem_wd = d_wdata.
  - The write commits at the same clk edge.
- Starvation counter:
  - Increments, saturating at MAX_STARVE, when if_req & !if_gnt.
  - Clears when if_gnt = 1 or if_req = 0.
- Response latency is exactly 1 cycle:
  - At the edge ending the grant cycle, the granted port's rvalid is set for one cycle.
  - rdata latches mem_rd (loads and fetches) or 0 (stores).
  - The non-granted rvalid is 0.
  - rdata holds its value until the next response for that port.
- Back-to-back grants to the same port give rvalid high on consecutive cycles.
- Store followed by a load to the same address on the next cycle returns the new data.
- Reset asserted mid-transaction drops any pending response: rvalid is 0 next cycle and no write occurs in the reset cycle.
- Requester protocol violations (request dropped before grant) are not checked; the arbiter simply re-evaluates each cycle.

Optional Feature:
- Macro: MEM_ARB_ADDR_CHECK_EN.
- When defined:
  - A granted access with word index (addr >> 2) >= MEM_WORDS, or with addr[1:0] != 0, is an error.
  - mem_we is suppressed for it.
  - The response still occurs (rvalid = 1, rdata = 0), and err pulses high in the same cycle as rvalid.
- When undefined:
  - err is tied 0.
  - Addresses pass through unchecked; the memory uses addr bits [AW-1:2].

Decomposition:
- Shared package mem_arb_pkg holds:
  - localparams AW, DW and MAX_STARVE defaults.
  - Port-select enum GNT_NONE, GNT_IF, GNT_D.
  - STARVE_W = 4 (counter width).
- One natural sub-module: mem_arb_starve_cnt, the saturating starvation counter with clear, exposing a "force_if" output.

Test Plan:
- Reset with reset_n = 0 for 2 cycles while if_req = d_req = 1 -> no grants, mem_we = 0, all rvalid/rdata/err = 0.
- IF only, if_addr = 0x0, then 0x4, then 0x8 -> if_gnt each cycle; if_rvalid on cycles +1..+3 with if_rdata = memory words 0, 1, 2.
- Store d_addr = 0x40, d_wdata = 0xDEADBEEF, then load 0x40 next cycle -> d_rvalid twice; second d_rdata = 0xDEADBEEF, first = 0.
- Both requesting continuously, MAX_STARVE = 4 -> grant pattern D, D, D, D, IF repeating; if_rvalid every 5th cycle.
- Reset asserted in the cycle after a granted load -> no d_rvalid afterward; memory contents unchanged.
- With MEM_ARB_ADDR_CHECK_EN: store to 0x200 (word 128) -> no write; d_rvalid = 1, d_rdata = 0, err = 1 for one cycle. Without the macro: err stays 0.
